// File: rtl/oled_source_arbiter.sv
// Frame-synchronous pixel source arbiter for an OLED driver.
// It switches between sources only on frame boundaries and inserts optional background frames between two sources.
module oled_source_arbiter #(
  parameter int              NCH          = 4,
  parameter int              PW           = 16,
  parameter int              BLANK_FRAMES = 2,
  parameter logic [PW-1:0]   BG_COLOR     = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_begin,
  input  logic [NCH-1:0]           sel,
  input  logic [NCH*PW-1:0]        pix_in,
  output logic [PW-1:0]            pix_out,
  output logic [$clog2(NCH)-1:0]   active_ch,
  output logic                     active_valid,
  output logic                     switching,
  output logic [7:0]               sw_count
);
  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  sel_q, sel_d;
  logic [CW-1:0]   active_ch_q, active_ch_d;
  logic [CW-1:0]   target_q, target_d;
  logic [3:0]      blank_cnt_q, blank_cnt_d;
  logic [7:0]      sw_count_q, sw_count_d;
  logic [PW-1:0]   pix_out_q, pix_out_d;

  logic [CW-1:0]   pend;
  logic            pend_valid;
  logic            sw_inc;
  logic [PW-1:0]   ch_pix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      active_ch_q <= '0;
      target_q    <= '0;
      blank_cnt_q <= '0;
      sw_count_q  <= '0;
      pix_out_q   <= BG_COLOR;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      active_ch_q <= active_ch_d;
      target_q    <= target_d;
      blank_cnt_q <= blank_cnt_d;
      sw_count_q  <= sw_count_d;
      pix_out_q   <= pix_out_d;
    end
  end

  // Lowest requesting index wins; scanning downward leaves the smallest set index last.
  always_comb begin
    pend = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (sel_q[i]) pend = CW'(i);
    pend_valid = |sel_q;
  end

  always_comb begin
    ch_pix = pix_in[PW-1:0];
    for (int i = 0; i < NCH; i++)
      if (active_ch_q == CW'(i)) ch_pix = pix_in[i*PW +: PW];
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    active_ch_d = active_ch_q;
    target_d    = target_q;
    blank_cnt_d = blank_cnt_q;
    sw_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_begin && pend_valid) begin
          state_d     = S_SHOW;
          active_ch_d = pend;
        end
      end
      S_SHOW: begin
        if (frame_begin && pend_valid && (pend != active_ch_q)) begin
          if (BLANK_FRAMES == 0) begin
            active_ch_d = pend;
            sw_inc      = 1'b1;
          end else begin
            target_d    = pend;
            blank_cnt_d = 4'(BLANK_FRAMES - 1);
            state_d     = S_BLANK;
          end
        end
      end
      S_BLANK: begin
        // An empty request keeps the latched target, so the blank still completes.
        if (frame_begin) begin
          if (pend_valid) target_d = pend;
          if (blank_cnt_q == 4'd0) begin
            state_d     = S_SHOW;
            active_ch_d = target_d;
            sw_inc      = 1'b1;
          end else begin
            blank_cnt_d = blank_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    sw_count_d = (sw_inc && (sw_count_q != 8'hFF)) ? sw_count_q + 8'd1 : sw_count_q;
    pix_out_d  = (state_q == S_SHOW) ? ch_pix : BG_COLOR;
  end

  always_comb begin
    active_valid = (state_q == S_SHOW);
    switching    = (state_q == S_BLANK);
    active_ch    = active_ch_q;
    sw_count     = sw_count_q;
    pix_out      = pix_out_q;
  end
endmodule

// File: doc/oled_source_arbiter.md
OLED_SOURCE_ARBITER -- requirements
Module: oled_source_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NCH, 4, number of pixel source channels (2..16).
- PW, 16, pixel width in bits (RGB565 at default).
- BLANK_FRAMES, 2, whole frames of background shown between two sources (0..15).
- BG_COLOR, 16'h0000, background pixel value; PW bits wide.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- frame_begin  in  1  single-cycle pulse marking start of a display frame, synchronous to clk.
- sel  in  NCH  source request vector; bit i requests channel i.
- pix_in  in  NCH*PW  channel pixels; channel i at bits [i*PW +: PW].
- pix_out  out  PW  registered pixel to the display driver.
- active_ch  out  CW  index of the channel currently shown; CW = max(1, clog2(NCH)).
- active_valid  out  1  high when a channel is being shown (state SHOW).
- switching  out  1  high while in state BLANK.
- sw_count  out  8  number of completed source switches, saturating.

REQ-003 The block SHALL have one clock (clk) and one reset (rst_n); reset is synchronous and active-low.

Function
REQ-004 sel SHALL be registered once (sel_q); all decisions use sel_q.
REQ-005 pending channel SHALL be the lowest index i with sel_q[i]=1; pending_valid = |sel_q.
REQ-006 sel_q all-zero SHALL cause no change of state, channel or counters (hold current source).
REQ-007 State changes SHALL occur only on cycles where frame_begin=1; between pulses, state, active_ch and target are frozen.
REQ-008 States SHALL be IDLE, SHOW, BLANK.
REQ-009 IDLE: pix_out = BG_COLOR. On frame_begin with pending_valid, go to SHOW with active_ch = pending, no blanking.
REQ-010 SHOW: pix_out SHALL equal pix_in[active_ch] registered, 1 clk latency.
REQ-011 SHOW: on frame_begin with pending_valid and pending != active_ch:
- BLANK_FRAMES>0: latch target = pending, load blank_cnt = BLANK_FRAMES-1, go to BLANK.
- BLANK_FRAMES=0: set active_ch = pending directly, stay SHOW, increment sw_count.
REQ-012 BLANK: pix_out = BG_COLOR, switching=1, active_valid=0; active_ch keeps the old channel.
REQ-013 BLANK, on frame_begin:
- if pending_valid, target <= pending (retarget; blank_cnt not restarted).
- if blank_cnt=0, go to SHOW with active_ch = updated target, increment sw_count.
- else decrement blank_cnt.
REQ-014 BLANK therefore SHALL span exactly BLANK_FRAMES frame_begin pulses after entry.
REQ-015 Retarget to the original channel during BLANK SHALL still complete the blank and count as a switch.
REQ-016 sw_count SHALL increment by 1 per completed switch and saturate at 255; IDLE->SHOW is not counted.
REQ-017 pix_out SHALL change only on the clock edge and be glitch-free; output mux width is exactly PW.
REQ-018 Combinational logic SHALL NOT form a path from sel or frame_begin to any output.

Reset
REQ-019 rst_n=0 at a clock edge SHALL force: state IDLE, pix_out=BG_COLOR, active_ch=0, active_valid=0, switching=0, sw_count=0, blank_cnt=0, target=0, sel_q=0.
REQ-020 Reset SHALL take priority over a coincident frame_begin; reset mid-BLANK abandons the switch (no count).
REQ-021 First frame_begin after reset release with sel_q nonzero SHALL enter SHOW.

Verification
REQ-022 Reset, sel=4'b0010, frame_begin pulse -> next cycle state SHOW, active_ch=1, active_valid=1; following cycle pix_out = pix_in ch1 value; sw_count=0.
REQ-023 SHOW ch1, sel=4'b0110 -> priority keeps ch1, no BLANK; sel=4'b0100 at frame_begin -> switching=1, pix_out=16'h0000 for 2 frames, SHOW ch2 on the 2nd following pulse, sw_count=1.
REQ-024 In BLANK, set sel=4'b1000 before last pulse -> exits to ch3, sw_count=1; sel=0 during BLANK -> exits to prior target.
REQ-025 sel changed mid-frame (no pulse) for 1000 cycles -> active_ch, state, pix_out source unchanged until next frame_begin.
REQ-026 BLANK_FRAMES=0, NCH=8: 300 alternating switches -> sw_count saturates at 255, no BLANK entry; rst_n=0 coincident with frame_begin mid-BLANK (default build) -> IDLE, all outputs per REQ-019.
